// File: rtl/onehot_xor_accum.sv
// One-hot decode/accumulate engine: walks an index table, folds each decoded index
// into an accumulator by XOR or OR, then registers popcount/parity for the LEDs.
module onehot_xor_accum #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned OUT_W = 2 ** IDX_W,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0] wr_data,
  input  logic             start,
  input  logic             mode_or,
  input  logic             pb1,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] acc,
  output logic [IDX_W:0]   popcount,
  output logic             parity,
  output logic [OUT_W-1:0] led
);

  typedef enum logic [1:0] {IDLE, RUN, STAT, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             mode;
  logic [IDX_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] onehot_c;
  logic [IDX_W:0]   ones_c;
  logic             wr_ok_c;

  function automatic logic [IDX_W:0] ones(input logic [OUT_W-1:0] v);
    logic [IDX_W:0] s;
    s = '0;
    for (int i = 0; i < int'(OUT_W); i++) s = s + (IDX_W+1)'(v[i]);
    return s;
  endfunction

  // Index 0 maps to the MSB: bit OUT_W-1-i is the bitwise inverse of i.
  always_comb begin
    onehot_c = OUT_W'(1) << (~mem[ptr]);
    ones_c   = ones(acc);
    wr_ok_c  = wr_en && (state == IDLE || state == DONE) && (32'(wr_addr) < DEPTH);
  end

  // Table storage is deliberately not reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      mode     <= 1'b0;
      acc      <= '0;
      popcount <= '0;
      parity   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      led      <= '0;
    end else begin
      led <= pb1 ? OUT_W'(parity) : acc;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= '0;
            ptr   <= '0;
            mode  <= mode_or;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= mode ? (acc | onehot_c) : (acc ^ onehot_c);
          if (ptr == PTR_W'(DEPTH - 1)) begin
            ptr   <= '0;
            state <= STAT;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        STAT: begin
          popcount <= ones_c;
          parity   <= ones_c[0];
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_xor_accum.sv
// Scoreboard bench for onehot_xor_accum: default instance (IDX_W=3, DEPTH=8) plus a
// small instance (IDX_W=2, DEPTH=5); results are checked when done rises.
module tb_onehot_xor_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic       wr_en, start, mode_or, pb1;
  logic [2:0] wr_addr, wr_data;
  logic       busy, done, parity;
  logic [7:0] acc, led;
  logic [3:0] popcount;

  // small instance
  logic       wr_en2, start2, mode2, pb2;
  logic [2:0] wr_addr2;
  logic [1:0] wr_data2;
  logic       busy2, done2, par2;
  logic [3:0] acc2, led2;
  logic [2:0] pc2;

  onehot_xor_accum dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode_or(mode_or), .pb1(pb1), .busy(busy), .done(done),
    .acc(acc), .popcount(popcount), .parity(parity), .led(led)
  );

  onehot_xor_accum #(.IDX_W(2), .DEPTH(5)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .start(start2), .mode_or(mode2), .pb1(pb2), .busy(busy2), .done(done2),
    .acc(acc2), .popcount(pc2), .parity(par2), .led(led2)
  );

  typedef struct {logic [7:0] acc; logic [3:0] pc; logic par;} exp_t;
  exp_t sb1[$];
  exp_t sb2[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitors: pop an expected result on every rising edge of done
  logic done_q = 1'b0, done2_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb1.size() == 0) chk("sb1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("acc", 32'(acc), 32'(e.acc));
        chk("popcount", 32'(popcount), 32'(e.pc));
        chk("parity", 32'(parity), 32'(e.par));
      end
    end
    if (done2 && !done2_q) begin
      if (sb2.size() == 0) chk("sb2_unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb2.pop_front();
        chk("acc2", 32'(acc2), 32'(e.acc));
        chk("popcount2", 32'(pc2), 32'(e.pc));
        chk("parity2", 32'(par2), 32'(e.par));
      end
    end
    done_q  = done;
    done2_q = done2;
  end

  task automatic write1(input logic [2:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic write2(input logic [2:0] a, input logic [1:0] d);
    wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    @(posedge clk); #1;
    wr_en2 = 1'b0;
  endtask

  // Start a run, optionally disturb it mid-walk, and check the start-to-done latency.
  task automatic run1(input logic m, input logic [7:0] ea, input logic [3:0] ep,
                      input logic epar, input bit disturb);
    exp_t e;
    int   n;
    bit   got;
    e.acc = ea; e.pc = ep; e.par = epar;
    sb1.push_back(e);
    mode_or = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode_or = ~m;
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      if (disturb && n == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'd7;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      got = done;
    end
    start = 1'b0; wr_en = 1'b0;
    chk("done_latency", 32'(got ? n : 99), 32'd9);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run2(input logic [3:0] ea, input logic [2:0] ep, input logic epar);
    exp_t e;
    int   n;
    e.acc = 8'(ea); e.pc = 4'(ep); e.par = epar;
    sb2.push_back(e);
    mode2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (n < 20 && !done2) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done2_latency", 32'(done2 ? n : 99), 32'd6);
  endtask

  logic [2:0] tbl1 [8];
  logic [1:0] tbl2 [5];

  initial begin
    tbl1 = '{3'd3, 3'd4, 3'd7, 3'd2, 3'd3, 3'd5, 3'd0, 3'd2};
    tbl2 = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2};
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; mode_or = 0; pb1 = 0;
    wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0; start2 = 0; mode2 = 0; pb2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_popcount", 32'(popcount), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // test 1: default table, XOR fold, then both display selections
    for (int i = 0; i < 8; i++) write1(3'(i), tbl1[i]);
    run1(1'b0, 8'h8D, 4'd4, 1'b0, 1'b0);
    pb1 = 1'b0;
    @(posedge clk); #1;
    chk("led_acc", 32'(led), 32'h8D);
    pb1 = 1'b1;
    @(posedge clk); #1;
    chk("led_parity", 32'(led), 32'h00);
    pb1 = 1'b0;

    // test 2: OR fold restarted from DONE
    run1(1'b1, 8'hBD, 4'd6, 1'b0, 1'b0);

    // test 4: start and write mid-run are ignored, table unchanged afterwards
    run1(1'b0, 8'h8D, 4'd4, 1'b0, 1'b1);
    run1(1'b0, 8'h8D, 4'd4, 1'b0, 1'b0);

    // test 5: reset during a run aborts at once, table survives
    pb1 = 1'b0; mode_or = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_led", 32'(led), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run1(1'b0, 8'h8D, 4'd4, 1'b0, 1'b0);

    // test 3: all-zero table
    for (int i = 0; i < 8; i++) write1(3'(i), 3'd0);
    run1(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    run1(1'b1, 8'h80, 4'd1, 1'b1, 1'b0);
    pb1 = 1'b1;
    @(posedge clk); #1;
    chk("led_parity_one", 32'(led), 32'h01);
    pb1 = 1'b0;

    // test 6: small instance, with out-of-range writes that must be dropped
    for (int i = 0; i < 5; i++) write2(3'(i), tbl2[i]);
    for (int a = 5; a < 8; a++) write2(3'(a), 2'd3);
    run2(4'hB, 3'd3, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb2_drained", 32'(sb2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
